display_scan_ctrl: RTL and testbench

Time-multiplexed scan sequencer for the 4-digit display path. It sits directly upstream of the 1-to-4 enable demultiplexer and drives that stage's 2-bit select and enable inputs. It rotates through digits 0..3 at a programmable rate and inserts a blanking gap between digits to suppress ghosting. It presents the matching 4-bit digit code, snapshotted per slot, to the segment decoder.

---
 rtl/display_scan_ctrl_pkg.sv | 19 +
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl_counter.sv | 28 ++
 rtl/display_scan_ctrl.sv | 117 +++++++++++
 tb/tb_display_scan_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit display scan sequencer.
package display_scan_ctrl_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEL_WIDTH  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      BLANK  = 2'd2
   } scan_state_e;

   // Picks the 4-bit code of digit idx out of the packed digit word.
   function automatic logic [3:0] digit_at(input logic [4*NUM_DIGITS-1:0] digits,
                                           input logic [SEL_WIDTH-1:0] idx);
      return digits[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control inputs and demux/decoder outputs of the display scan sequencer.
interface display_scan_ctrl_if;
   import display_scan_ctrl_pkg::*;

   logic                    input_run;
   logic [4*NUM_DIGITS-1:0] input_digits;
   logic [NUM_DIGITS-1:0]   input_mask;
   logic [SEL_WIDTH-1:0]    out_sel;
   logic                    out_e;
   logic [3:0]              out_nibble;
   logic                    out_frame;

   modport master (
      output input_run, input_digits, input_mask,
      input  out_sel, out_e, out_nibble, out_frame
   );

   modport slave (
      input  input_run, input_digits, input_mask,
      output out_sel, out_e, out_nibble, out_frame
   );

endinterface

// File: rtl/display_scan_ctrl_counter.sv
// Slot cycle counter shared by the active and blanking phases.
// done is high while the count equals cmp; clr restarts from zero.
module scan_cycle_counter #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 input_clk,
   input  logic                 input_reset_n,
   input  logic                 clr,
   input  logic [DIV_WIDTH-1:0] cmp,
   output logic                 done
);

   logic [DIV_WIDTH-1:0] count_q;

   // Free-running up-count, cleared at the end of each phase or when idle.
   always_ff @(posedge input_clk or negedge input_reset_n) begin
      if (!input_reset_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 1'b1;
      end
   end

   assign done = (count_q == cmp);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan sequencer for the 4-digit display.
//
//   state  | meaning
//   IDLE   | scan disabled, all outputs at reset values
//   ACTIVE | digit slot running, demux enabled if digit unmasked
//   BLANK  | anti-ghosting gap between slots, demux disabled
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int DIV_WIDTH    = 16,
   parameter int DIV_MAX      = 49999,
   parameter int BLANK_CYCLES = 500
) (
   input  logic               input_clk,
   input  logic               input_reset_n,
   display_scan_ctrl_if.slave bus
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(DIV_MAX);
   localparam logic [DIV_WIDTH-1:0] BLANK_LAST =
      (BLANK_CYCLES == 0) ? '0 : DIV_WIDTH'(BLANK_CYCLES - 1);

   scan_state_e          state_q, state_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic [3:0]           nibble_q, nibble_d;
   logic                 e_q, e_d;
   logic                 frame_q, frame_d;
   logic                 cnt_clr, cnt_done, advance;
   logic [DIV_WIDTH-1:0] cnt_cmp;

   scan_cycle_counter #(.DIV_WIDTH(DIV_WIDTH)) u_cnt (
      .input_clk     (input_clk),
      .input_reset_n (input_reset_n),
      .clr           (cnt_clr),
      .cmp           (cnt_cmp),
      .done          (cnt_done)
   );

   // State, select, nibble and output flops.
   always_ff @(posedge input_clk or negedge input_reset_n) begin
      if (!input_reset_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         nibble_q <= '0;
         e_q      <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         nibble_q <= nibble_d;
         e_q      <= e_d;
         frame_q  <= frame_d;
      end
   end

   // Next-state logic; the nibble is reloaded only when the select moves,
   // so digit changes inside a slot wait for the next slot.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      nibble_d = nibble_q;
      frame_d  = 1'b0;
      cnt_clr  = 1'b0;
      cnt_cmp  = DIV_LAST;
      advance  = 1'b0;
      if (!bus.input_run) begin
         state_d  = IDLE;
         sel_d    = '0;
         nibble_d = '0;
         cnt_clr  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = ACTIVE;
               sel_d    = '0;
               nibble_d = digit_at(bus.input_digits, '0);
               cnt_clr  = 1'b1;
            end
            ACTIVE: begin
               cnt_cmp = DIV_LAST;
               if (cnt_done) begin
                  cnt_clr = 1'b1;
                  if (BLANK_CYCLES == 0) begin
                     advance = 1'b1;
                  end else begin
                     state_d = BLANK;
                  end
               end
            end
            BLANK: begin
               cnt_cmp = BLANK_LAST;
               if (cnt_done) begin
                  cnt_clr = 1'b1;
                  state_d = ACTIVE;
                  advance = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         endcase
      end
      if (advance) begin
         sel_d    = sel_q + 1'b1;
         nibble_d = digit_at(bus.input_digits, sel_d);
         frame_d  = (sel_q == SEL_WIDTH'(NUM_DIGITS - 1));
      end
      e_d = (state_d == ACTIVE) & bus.input_mask[sel_d];
   end

   assign bus.out_sel    = sel_q;
   assign bus.out_e      = e_q;
   assign bus.out_nibble = nibble_q;
   assign bus.out_frame  = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV_MAX=3; one instance with a
// 2-cycle gap and one with no gap.
module tb_display_scan_ctrl;
   import display_scan_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   display_scan_ctrl_if if_a ();
   display_scan_ctrl_if if_b ();

   always #5 clk = ~clk;

   display_scan_ctrl #(.DIV_WIDTH(16), .DIV_MAX(3), .BLANK_CYCLES(2)) u_dut (
      .input_clk     (clk),
      .input_reset_n (rst_n),
      .bus           (if_a.slave)
   );

   display_scan_ctrl #(.DIV_WIDTH(16), .DIV_MAX(3), .BLANK_CYCLES(0)) u_dut0 (
      .input_clk     (clk),
      .input_reset_n (rst_n),
      .bus           (if_b.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_a(input string tag, input int sel, input int nib, input int e, input int fr);
      chk({tag, ".sel"},    32'(if_a.out_sel),    32'(sel));
      chk({tag, ".nibble"}, 32'(if_a.out_nibble), 32'(nib));
      chk({tag, ".e"},      32'(if_a.out_e),      32'(e));
      chk({tag, ".frame"},  32'(if_a.out_frame),  32'(fr));
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      int sel;
      int act;
      int nib;
      logic [3:0] m;

      rst_n = 1'b0;
      if_a.input_run = 1'b0; if_a.input_mask = 4'hF; if_a.input_digits = 16'h4321;
      if_b.input_run = 1'b0; if_b.input_mask = 4'hF; if_b.input_digits = 16'h4321;
      cyc();
      chk_a("reset", 0, 0, 0, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_a("idle_run0", 0, 0, 0, 0);

      // Full frame, all digits lit
      if_a.input_run = 1'b1;
      for (int k = 0; k <= 24; k++) begin
         cyc();
         sel = (k / 6) % 4;
         act = ((k % 6) < 4) ? 1 : 0;
         chk_a($sformatf("scan_k%0d", k), sel, sel + 1, act, (k == 24) ? 1 : 0);
      end
      if_a.input_run = 1'b0;
      cyc();
      chk_a("stop_a", 0, 0, 0, 0);
      cyc();
      chk_a("stop_a_hold", 0, 0, 0, 0);

      // Masked digits, plus a mid-slot mask change on digit 1
      if_a.input_mask = 4'b1010;
      if_a.input_run  = 1'b1;
      for (int k = 0; k < 24; k++) begin
         cyc();
         sel = (k / 6) % 4;
         act = ((k % 6) < 4) ? 1 : 0;
         m   = if_a.input_mask;
         chk($sformatf("mask_k%0d.sel", k), 32'(if_a.out_sel), 32'(sel));
         chk($sformatf("mask_k%0d.e", k), 32'(if_a.out_e), 32'((act != 0) && m[sel]));
         if (k == 7) if_a.input_mask = 4'b1000;
         if (k == 9) if_a.input_mask = 4'b1010;
      end
      if_a.input_run = 1'b0;
      cyc();

      // Digit change inside slot 1, then abort in slot 2
      if_a.input_mask   = 4'hF;
      if_a.input_digits = 16'h4321;
      if_a.input_run    = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         cyc();
         sel = k / 6;
         nib = (k >= 12) ? 9 : sel + 1;
         chk($sformatf("snap_k%0d.sel", k), 32'(if_a.out_sel), 32'(sel));
         chk($sformatf("snap_k%0d.nibble", k), 32'(if_a.out_nibble), 32'(nib));
         if (k == 7) if_a.input_digits = 16'h9999;
      end
      if_a.input_run = 1'b0;
      cyc();
      chk_a("abort", 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_a($sformatf("abort_hold%0d", k), 0, 0, 0, 0);
      end

      // Restart: digit 0, no frame pulse
      if_a.input_digits = 16'h4321;
      if_a.input_run    = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         cyc();
         sel = k / 6;
         act = ((k % 6) < 4) ? 1 : 0;
         chk_a($sformatf("restart_k%0d", k), sel, sel + 1, act, 0);
      end

      // Asynchronous reset in the middle of the slot-1 gap
      #2 rst_n = 1'b0;
      #1 chk_a("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      chk_a("async_rst_hold", 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc();
      chk_a("post_rst_k0", 0, 1, 1, 0);
      cyc();
      chk_a("post_rst_k1", 0, 1, 1, 0);
      if_a.input_run = 1'b0;

      // No blanking gap: continuous enable, 4-cycle slots, 16-cycle frame
      if_b.input_run = 1'b1;
      for (int k = 0; k <= 32; k++) begin
         cyc();
         sel = (k / 4) % 4;
         chk($sformatf("nogap_k%0d.sel", k), 32'(if_b.out_sel), 32'(sel));
         chk($sformatf("nogap_k%0d.nibble", k), 32'(if_b.out_nibble), 32'(sel + 1));
         chk($sformatf("nogap_k%0d.e", k), 32'(if_b.out_e), 32'd1);
         chk($sformatf("nogap_k%0d.frame", k), 32'(if_b.out_frame),
             32'((k == 16 || k == 32) ? 1 : 0));
      end
      if_b.input_run = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
